param_mod_counter: RTL
======================

PARAM_MOD_COUNTER -- requirements
Module: param_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits.
REQ-002 Parameter MODULUS, default 10, count range 0..MODULUS-1.
REQ-003 Parameter DIV, default 25_000_000, enabled clk_50M cycles per count step.
REQ-004 clk_50M  in  1  system clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  in  1  reset; synchronous and active-low.
REQ-006 en  in  1  count enable; 0 freezes prescaler and count.
REQ-007 up_dn  in  1  direction: 1 = up, 0 = down.
REQ-008 load  in  1  synchronous load strobe.
REQ-009 load_val  in  WIDTH  value loaded into Q.
REQ-010 Q  out  WIDTH  registered count value.
REQ-011 tick  out  1  registered one-cycle strobe marking each count step.
REQ-012 tc  out  1  registered one-cycle terminal-count (wrap) strobe.
REQ-013 gray  out  WIDTH  registered Gray code of Q; present only with GRAY_OUT_EN.

Function
REQ-014 Internal prescaler pcnt (width clog2(DIV), min 1) SHALL count 0..DIV-1 on each edge with en=1 and load=0.
REQ-015 Step edge: en=1, load=0, pcnt==DIV-1 -> pcnt<=0, tick<=1, Q<=next value; all other edges tick<=0.
REQ-016 Up step: Q<=Q+1; at Q==MODULUS-1, Q<=0 and tc<=1.
REQ-017 Down step: Q<=Q-1; at Q==0, Q<=MODULUS-1 and tc<=1.
REQ-018 tc SHALL be 1 only on the step edge that wraps; otherwise 0.
REQ-019 DIV=1: a step SHALL occur on every edge with en=1.
REQ-020 load=1 SHALL override en: Q<=load_val, pcnt<=0, tick<=0, tc<=0.
REQ-021 load_val >= MODULUS SHALL load MODULUS-1.
REQ-022 en=0 SHALL hold Q and pcnt; tick and tc SHALL be 0.
REQ-023 up_dn is sampled on the step edge only; changing it mid-prescale SHALL NOT disturb pcnt.
REQ-024 Elaboration SHALL fail unless 2 <= MODULUS <= 2**WIDTH and DIV >= 1.

Reset
REQ-025 rst_n=0 at an edge SHALL set Q=0, pcnt=0, tick=0, tc=0 and gray=0, taking priority over load and en.
REQ-026 Reset asserted mid-prescale SHALL discard the partial count; the first step after release SHALL come DIV enabled edges later.

Configuration
REQ-027 Macro GRAY_OUT_EN defined: port gray present, registered from the next value of Q so that gray == Q ^ (Q>>1) on every cycle.
REQ-028 GRAY_OUT_EN undefined: port gray and its register SHALL be absent; all other behaviour unchanged.

Structure
REQ-029 Package counter_pkg SHALL hold the default constants (CNT_WIDTH_DEF=4, CNT_MOD_DEF=10, CNT_DIV_DEF=25_000_000) and a dir_t typedef (DIR_DOWN=0, DIR_UP=1).
REQ-030 The prescaler SHALL be the sub-module tick_gen (inputs clk_50M, rst_n, en, clr; parameter DIV; output step), instantiated once.

Verification (WIDTH=4, MODULUS=10, DIV=3 unless noted)
REQ-031 rst_n=0 for 2 edges with en=1 -> Q=0, tick=0, tc=0; after release with en=1 -> first tick and Q=1 on the 3rd edge.
REQ-032 Up from Q=0, en=1 for 30 edges -> Q=0 with tc=1 for exactly one cycle, on the 10th tick.
REQ-033 up_dn=0 from Q=0 -> next step gives Q=9 and tc=1; the following step gives Q=8 and tc=0.
REQ-034 load=1, load_val=7 with en=1 at pcnt=1 -> Q=7 and tick=0 on the next edge; Q=8 three enabled edges later. load_val=12 -> Q=9.
REQ-035 en=0 for 5 edges at pcnt=1 -> Q, pcnt frozen and tick=0; after en returns to 1, tick SHALL assert on the 2nd enabled edge.
REQ-036 GRAY_OUT_EN defined, step from Q=7 to Q=8 -> gray changes from 0100 to 1100 on the same edge as Q.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared defaults and direction encoding for the modulo counter slice.
package counter_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 4;
  localparam int unsigned CNT_MOD_DEF   = 10;
  localparam int unsigned CNT_DIV_DEF   = 25_000_000;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  // Prescaler width: clog2(div), never narrower than one bit (div == 1 case).
  function automatic int unsigned pcnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/param_mod_counter_tick_gen.sv
// Prescaler: counts enabled edges 0..DIV-1 and flags the edge that completes a period.
module tick_gen
  import counter_pkg::*;
#(
  parameter int unsigned DIV = CNT_DIV_DEF
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int unsigned    PW   = pcnt_width(DIV);
  localparam logic [PW-1:0]  LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;

  always_comb begin
    step   = en && !clr && (pcnt_q == LAST);
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = (pcnt_q == LAST) ? '0 : pcnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/param_mod_counter.sv
// Prescaled up/down modulo counter with load, tick and terminal-count strobes.
// Optional registered Gray output enabled by defining GRAY_OUT_EN.
module param_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = CNT_WIDTH_DEF,
  parameter int unsigned MODULUS = CNT_MOD_DEF,
  parameter int unsigned DIV     = CNT_DIV_DEF
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tick,
  output logic             tc
`ifdef GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] gray
`endif
);

  if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH) || DIV < 1) begin : g_param_check
    $error("param_mod_counter: need 2 <= MODULUS <= 2**WIDTH and DIV >= 1");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  logic             step;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (load),
    .step    (step)
  );

  always_comb begin
    q_d    = q_q;
    tick_d = 1'b0;
    tc_d   = 1'b0;
    if (load) begin
      q_d = (32'(load_val) >= MODULUS) ? MAX_Q : load_val;
    end else if (step) begin
      tick_d = 1'b1;
      if (dir_t'(up_dn) == DIR_UP) begin
        if (q_q == MAX_Q) begin
          q_d  = '0;
          tc_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
          q_d  = MAX_Q;
          tc_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      q_q    <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      q_q    <= q_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
    end
  end

  assign Q    = q_q;
  assign tick = tick_q;
  assign tc   = tc_q;

`ifdef GRAY_OUT_EN
  // Encoded from the next count so gray tracks Q on the same edge.
  logic [WIDTH-1:0] gray_q, gray_d;

  always_comb begin
    gray_d = q_d ^ (q_d >> 1);
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      gray_q <= '0;
    end else begin
      gray_q <= gray_d;
    end
  end

  assign gray = gray_q;
`endif

endmodule
